stopwatch_timekeeper: RTL and testbench
=======================================

# stopwatch_timekeeper

Consumer side of the stopwatch clock divider: samples the divided toggle clocks `sec_clk` and `blink_clk` in the `clk` domain and turns their rising edges into single-cycle internal strobes. Uses those strobes to run a BCD MM:SS stopwatch counter with run/pause, clear and manual adjust modes. Feeds four BCD digits and per-digit blank flags to the display multiplexer, which is clocked by `display_clk`.

## Interface
- No parameters.
- `clk` in 1: master clock.
- `rst` in 1: reset, synchronous, active-high.
- `sec_clk` in 1: 1 Hz toggle clock from the divider, 50% duty. Each half-period is ≥4 `clk` cycles.
- `blink_clk` in 1: blink toggle clock from the divider. Each half-period is ≥4 `clk` cycles.
- `run_toggle` in 1: single-cycle pulse, debounced upstream. Toggles run/pause.
- `clear` in 1: single-cycle pulse. Zeroes the count.
- `adj` in 1: level. High selects adjust mode.
- `sel` in 1: level. Selects the adjust field: 0 = seconds, 1 = minutes.
- `min_tens`, `min_ones`, `sec_tens`, `sec_ones` out 4 each: registered BCD digits.
- `running` out 1: high in RUN state.
- `blank` out 4: per-digit blank flags, bit3 = `min_tens` … bit0 = `sec_ones`.
- `wrap` out 1: one-cycle pulse when the count rolls over 99:59 → 00:00.

## Operation
- **Input sync:** each toggle clock passes through a 2-flop synchronizer (`s1`, `s2`) plus a history flop `p`.
  - Rising-edge strobe = `s2 & ~p`.
  - `s1`, `s2` and `p` all reset to 1, so no edge is detected until the input has been sampled low at least once. This prevents a spurious tick when reset releases while `sec_clk` is high.
- **State machine:** STOPPED (reset state), RUN, ADJUST.
  - STOPPED → RUN on `run_toggle` with `adj`=0.
  - RUN → STOPPED on `run_toggle`.
  - Any state → ADJUST while `adj`=1. `run_toggle` is ignored in ADJUST.
  - ADJUST → STOPPED the cycle after `adj` falls.
- **RUN counting:** each `sec_clk` strobe increments MM:SS.
  - `sec_ones` goes 9 → 0 with carry into `sec_tens`; `sec_tens` goes 5 → 0 with carry into minutes.
  - Minutes count 00–99. Digit counters never hold values outside their BCD ranges.
  - `sec_clk` strobes are ignored in STOPPED and ADJUST.
- **99:59 + tick:** goes to 00:00, `wrap`=1 for exactly one cycle, state stays RUN. The `STOPWATCH_SATURATE_EN` variant is described under Configuration.
- **ADJUST:** each `blink_clk` strobe increments the selected field only, with no carry between fields.
  - Seconds field: 59 → 00.
  - Minutes field: 99 → 00. `wrap` is not asserted.
- **clear:** forces 00:00 in any state and leaves the state unchanged.
  - `clear` beats a tick or adjust increment in the same cycle.
  - `clear` and `run_toggle` in the same cycle both take effect.
- **blank:** combinational from registered state.
  - In ADJUST, the selected pair is blanked while the synchronized `blink_clk` level (`s2`) is 1: `sel`=0 gives 4'b0011, `sel`=1 gives 4'b1100.
  - Otherwise `blank` = 4'b0000.
- **Reset values:** all digits 0, `running`=0, `wrap`=0, `blank`=0, state STOPPED.

## Timing
- **Tick latency:** counting clk edges from the first edge that samples `sec_clk`=1:
  - edge 1 loads `s1`; edge 2 loads `s2`, which raises the strobe;
  - edge 3 updates the digits and loads `p`.
  - Digits are therefore visible after edge 3. `blink_clk` adjust increments have the same latency.
- **Strobe width:** exactly one strobe per input rising edge. Falling edges produce nothing.
- **Control latency:** `run_toggle` and `clear` take effect at the next clk edge; `running` changes at that edge.
- **State-change race:** a strobe that arrives in the same cycle that `run_toggle` starts RUN is not counted, because the state is still STOPPED.
- **Reset mid-operation:** digits are cleared and sync flops go to 1 at the reset edge. The first post-reset tick requires a new low→high transition on the input.

## Configuration
- `STOPWATCH_SATURATE_EN` defined:
  - In RUN, a tick at 99:59 holds 99:59 and forces the state to STOPPED (`running`=0).
  - `wrap` is tied to 0.
- `STOPWATCH_SATURATE_EN` undefined: the count wraps to 00:00 with a one-cycle `wrap` pulse, as described above.
- ADJUST wrap behaviour is identical in both builds.

## Test plan
- **Basic count:** reset, `run_toggle`, then 3 `sec_clk` periods → 00:03. Each digit change lands on the 3rd clk edge after `sec_clk` is sampled high; `running`=1.
- **Adjust then carry:** `adj`=1, `sel`=1 with 5 blink edges → 05:00; `sel`=0 with 59 blink edges → 05:59. Then `adj`=0, `run_toggle`, one tick → 06:00.
- **Wrap:** preload 99:59, run, one tick → 00:00 with `wrap` high for exactly 1 cycle. With `STOPWATCH_SATURATE_EN`: holds 99:59, `running`=0, `wrap`=0.
- **Clear collision:** in RUN at 00:42, `clear` on the strobe cycle → 00:00 and `running` stays 1.
- **Reset glitch and pause:**
  - Assert `rst` while `sec_clk`=1, then release → no increment until the next `sec_clk` rising edge.
  - `run_toggle` twice then 2 ticks → count unchanged.
- **Blink mask:** `adj`=1, `sel`=0 → `blank`=4'b0011 while `blink_clk` is high and 4'b0000 while low. `sel`=1 → 4'b1100. `run_toggle` in ADJUST is ignored.

Source files
------------

// File: rtl/stopwatch_timekeeper.sv
// stopwatch_timekeeper
// Consumer side of the stopwatch clock divider. Synchronizes the divided
// toggle clocks into the clk domain, turns their rising edges into one-cycle
// strobes, and runs a BCD MM:SS stopwatch with run/pause, clear and adjust.
//
// Ports:
//   clk, rst             master clock, synchronous active-high reset
//   sec_clk, blink_clk   divided toggle clocks (asynchronous to clk)
//   run_toggle, clear    single-cycle control pulses
//   adj, sel             adjust-mode level and field select (0 = sec, 1 = min)
//   min_tens .. sec_ones registered BCD digits
//   running              high in RUN
//   blank                per-digit blank flags (bit3 = min_tens), combinational
//   wrap                 one-cycle pulse on 99:59 -> 00:00 rollover
//
// Build option: define STOPWATCH_SATURATE_EN to hold at 99:59 and stop
// instead of wrapping (wrap is then never asserted).
module stopwatch_timekeeper (
    input  logic       clk,
    input  logic       rst,
    input  logic       sec_clk,
    input  logic       blink_clk,
    input  logic       run_toggle,
    input  logic       clear,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic [3:0] blank,
    output logic       wrap
);

    localparam int unsigned DW = 4;

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_RUN     = 2'd1,
        ST_ADJUST  = 2'd2
    } state_t;

    state_t state, state_n;

    logic sec_s1, sec_s2, sec_p;
    logic blk_s1, blk_s2, blk_p;
    logic sec_stb, blk_stb;

    logic [DW-1:0] mt_n, mo_n, st_n, so_n;
    logic          wrap_n;
    logic          sec_max, min_max;

    // Synchronizers reset high so a level already high at reset release
    // does not produce an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sec_s1 <= 1'b1;
            sec_s2 <= 1'b1;
            sec_p  <= 1'b1;
            blk_s1 <= 1'b1;
            blk_s2 <= 1'b1;
            blk_p  <= 1'b1;
        end else begin
            sec_s1 <= sec_clk;
            sec_s2 <= sec_s1;
            sec_p  <= sec_s2;
            blk_s1 <= blink_clk;
            blk_s2 <= blk_s1;
            blk_p  <= blk_s2;
        end
    end

    assign sec_stb = sec_s2 & ~sec_p;
    assign blk_stb = blk_s2 & ~blk_p;

    assign sec_max = (sec_tens == DW'(5)) && (sec_ones == DW'(9));
    assign min_max = (min_tens == DW'(9)) && (min_ones == DW'(9));

    // State and digit registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_STOPPED;
            min_tens <= '0;
            min_ones <= '0;
            sec_tens <= '0;
            sec_ones <= '0;
            running  <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            state    <= state_n;
            min_tens <= mt_n;
            min_ones <= mo_n;
            sec_tens <= st_n;
            sec_ones <= so_n;
            running  <= (state_n == ST_RUN);
            wrap     <= wrap_n;
        end
    end

    // Next-state and next-count logic.
    always_comb begin
        state_n = state;
        mt_n    = min_tens;
        mo_n    = min_ones;
        st_n    = sec_tens;
        so_n    = sec_ones;
        wrap_n  = 1'b0;

        if (adj) begin
            state_n = ST_ADJUST;
        end else begin
            case (state)
                ST_STOPPED: if (run_toggle) state_n = ST_RUN;
                ST_RUN:     if (run_toggle) state_n = ST_STOPPED;
                ST_ADJUST:  state_n = ST_STOPPED;
                default:    state_n = ST_STOPPED;
            endcase
        end

        // Clear has priority over any increment in the same cycle.
        if (clear) begin
            mt_n = '0;
            mo_n = '0;
            st_n = '0;
            so_n = '0;
        end else if (state == ST_RUN && sec_stb) begin
            if (sec_max && min_max) begin
`ifdef STOPWATCH_SATURATE_EN
                if (!adj) state_n = ST_STOPPED;
`else
                mt_n   = '0;
                mo_n   = '0;
                st_n   = '0;
                so_n   = '0;
                wrap_n = 1'b1;
`endif
            end else if (sec_ones != DW'(9)) begin
                so_n = DW'(sec_ones + DW'(1));
            end else begin
                so_n = '0;
                if (sec_tens != DW'(5)) begin
                    st_n = DW'(sec_tens + DW'(1));
                end else begin
                    // Not at 99:59 here, so min_tens cannot overflow.
                    st_n = '0;
                    if (min_ones != DW'(9)) begin
                        mo_n = DW'(min_ones + DW'(1));
                    end else begin
                        mo_n = '0;
                        mt_n = DW'(min_tens + DW'(1));
                    end
                end
            end
        end else if (state == ST_ADJUST && blk_stb) begin
            // Adjust bumps one field only, never carrying into the other.
            if (sel) begin
                if (min_ones != DW'(9)) begin
                    mo_n = DW'(min_ones + DW'(1));
                end else begin
                    mo_n = '0;
                    mt_n = (min_tens == DW'(9)) ? '0 : DW'(min_tens + DW'(1));
                end
            end else begin
                if (sec_ones != DW'(9)) begin
                    so_n = DW'(sec_ones + DW'(1));
                end else begin
                    so_n = '0;
                    st_n = (sec_tens == DW'(5)) ? '0 : DW'(sec_tens + DW'(1));
                end
            end
        end
    end

    // Blink mask for the field being adjusted.
    always_comb begin
        blank = 4'b0000;
        if (state == ST_ADJUST && blk_s2)
            blank = sel ? 4'b1100 : 4'b0011;
    end

endmodule

// File: tb/tb_stopwatch_timekeeper.sv
// Directed self-checking bench for stopwatch_timekeeper.
module tb_stopwatch_timekeeper;

    logic       clk;
    logic       rst;
    logic       sec_clk;
    logic       blink_clk;
    logic       run_toggle;
    logic       clear;
    logic       adj;
    logic       sel;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       running;
    logic [3:0] blank;
    logic       wrap;
    logic [15:0] digits;

    int checks = 0;
    int errors = 0;
    int wrap_cnt = 0;
    int w0;

    stopwatch_timekeeper dut (
        .clk       (clk),
        .rst       (rst),
        .sec_clk   (sec_clk),
        .blink_clk (blink_clk),
        .run_toggle(run_toggle),
        .clear     (clear),
        .adj       (adj),
        .sel       (sel),
        .min_tens  (min_tens),
        .min_ones  (min_ones),
        .sec_tens  (sec_tens),
        .sec_ones  (sec_ones),
        .running   (running),
        .blank     (blank),
        .wrap      (wrap)
    );

    assign digits = {min_tens, min_ones, sec_tens, sec_ones};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (wrap === 1'b1) wrap_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sec_pulse();
        sec_clk = 1'b1; cyc(4);
        sec_clk = 1'b0; cyc(4);
    endtask

    task automatic blink_pulses(input int n);
        repeat (n) begin
            blink_clk = 1'b1; cyc(4);
            blink_clk = 1'b0; cyc(4);
        end
    endtask

    task automatic pulse_run();
        run_toggle = 1'b1; cyc(1); run_toggle = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1; cyc(1); clear = 1'b0;
    endtask

    initial begin
        rst = 1'b1; sec_clk = 1'b0; blink_clk = 1'b0;
        run_toggle = 1'b0; clear = 1'b0; adj = 1'b0; sel = 1'b0;
        cyc(3);
        rst = 1'b0;
        chk("reset_digits", 32'(digits), 32'h0000);
        chk("reset_running", 32'(running), 32'd0);
        chk("reset_wrap", 32'(wrap), 32'd0);
        chk("reset_blank", 32'(blank), 32'd0);

        // Basic count with tick latency.
        pulse_run();
        chk("run_start", 32'(running), 32'd1);
        sec_clk = 1'b1;
        cyc(2);
        chk("tick_edge2", 32'(digits), 32'h0000);
        cyc(1);
        chk("tick_edge3", 32'(digits), 32'h0001);
        cyc(1);
        sec_clk = 1'b0; cyc(4);
        chk("falling_no_tick", 32'(digits), 32'h0001);
        sec_pulse();
        sec_pulse();
        chk("count_3", 32'(digits), 32'h0003);
        chk("count_running", 32'(running), 32'd1);

        // Adjust then carry.
        adj = 1'b1; sel = 1'b1; cyc(1);
        chk("adj_running", 32'(running), 32'd0);
        pulse_clear();
        chk("adj_clear", 32'(digits), 32'h0000);
        sec_pulse();
        chk("adj_ignores_tick", 32'(digits), 32'h0000);
        blink_pulses(5);
        chk("adj_min_5", 32'(digits), 32'h0500);
        sel = 1'b0;
        blink_pulses(59);
        chk("adj_sec_59", 32'(digits), 32'h0559);
        adj = 1'b0; cyc(1);
        chk("adj_exit", 32'(running), 32'd0);
        pulse_run();
        sec_pulse();
        chk("carry_0600", 32'(digits), 32'h0600);

        // Clear colliding with a tick strobe.
        adj = 1'b1; sel = 1'b0; cyc(1);
        pulse_clear();
        blink_pulses(42);
        chk("preload_42", 32'(digits), 32'h0042);
        adj = 1'b0; cyc(1);
        pulse_run();
        chk("run_42", 32'(running), 32'd1);
        sec_clk = 1'b1; cyc(2);
        clear = 1'b1; cyc(1); clear = 1'b0;
        chk("clear_beats_tick", 32'(digits), 32'h0000);
        chk("clear_keeps_run", 32'(running), 32'd1);
        cyc(1); sec_clk = 1'b0; cyc(4);
        chk("clear_no_late_tick", 32'(digits), 32'h0000);

        // Adjust field wrap and preload to 99:59.
        adj = 1'b1; cyc(1);
        pulse_clear();
        sel = 1'b0;
        blink_pulses(60);
        chk("adj_sec_wrap", 32'(digits), 32'h0000);
        blink_pulses(59);
        sel = 1'b1;
        blink_pulses(99);
        chk("adj_9959", 32'(digits), 32'h9959);
        w0 = wrap_cnt;
        blink_pulses(1);
        chk("adj_min_wrap", 32'(digits), 32'h0059);
        chk("adj_min_wrap_nowrap", 32'(wrap_cnt - w0), 32'd0);
        blink_pulses(99);
        chk("adj_9959_again", 32'(digits), 32'h9959);
        adj = 1'b0; cyc(1);
        pulse_run();
        w0 = wrap_cnt;
        sec_clk = 1'b1; cyc(2);
        chk("wrap_pre", 32'(wrap), 32'd0);
        cyc(1);
`ifdef STOPWATCH_SATURATE_EN
        chk("sat_digits", 32'(digits), 32'h9959);
        chk("sat_running", 32'(running), 32'd0);
        chk("sat_wrap", 32'(wrap), 32'd0);
        cyc(1);
        chk("sat_wrap_count", 32'(wrap_cnt - w0), 32'd0);
`else
        chk("wrap_digits", 32'(digits), 32'h0000);
        chk("wrap_pulse", 32'(wrap), 32'd1);
        chk("wrap_running", 32'(running), 32'd1);
        cyc(1);
        chk("wrap_drop", 32'(wrap), 32'd0);
        chk("wrap_count", 32'(wrap_cnt - w0), 32'd1);
`endif
        sec_clk = 1'b0; cyc(4);

        // Reset while sec_clk is high: no tick until a fresh rising edge.
        sec_clk = 1'b1; rst = 1'b1; cyc(2);
        rst = 1'b0;
        chk("rst_digits", 32'(digits), 32'h0000);
        pulse_run();
        cyc(5);
        chk("rst_no_glitch", 32'(digits), 32'h0000);
        chk("rst_run", 32'(running), 32'd1);
        sec_clk = 1'b0; cyc(4);
        sec_clk = 1'b1; cyc(4);
        chk("rst_first_tick", 32'(digits), 32'h0001);
        sec_clk = 1'b0; cyc(4);

        // Pause, ticks ignored, then a resume racing a strobe.
        pulse_run();
        chk("pause_running", 32'(running), 32'd0);
        sec_pulse();
        sec_pulse();
        chk("pause_hold", 32'(digits), 32'h0001);
        sec_clk = 1'b1; cyc(2);
        run_toggle = 1'b1; cyc(1); run_toggle = 1'b0;
        chk("race_running", 32'(running), 32'd1);
        chk("race_not_counted", 32'(digits), 32'h0001);
        cyc(1); sec_clk = 1'b0; cyc(4);
        sec_pulse();
        chk("resume_tick", 32'(digits), 32'h0002);

        // Blink mask.
        adj = 1'b1; sel = 1'b0; cyc(1);
        chk("blank_low", 32'(blank), 32'h0);
        blink_clk = 1'b1; cyc(2);
        chk("blank_sec", 32'(blank), 32'h3);
        run_toggle = 1'b1; cyc(1); run_toggle = 1'b0;
        chk("adj_ignores_run", 32'(running), 32'd0);
        sel = 1'b1; #1;
        chk("blank_min", 32'(blank), 32'hc);
        blink_clk = 1'b0; cyc(2);
        chk("blank_min_low", 32'(blank), 32'h0);
        blink_clk = 1'b1; cyc(2);
        adj = 1'b0; cyc(1);
        chk("blank_exit", 32'(blank), 32'h0);
        blink_clk = 1'b0; cyc(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
